// File: rtl/adc_sched.sv
// adc_sched: periodic ADC conversion scheduler with conversion timeout, power-of-two
// window averaging and window min/max; one averaged result per completed window.
module adc_sched #(
   parameter int PERIOD   = 50000,
   parameter int AVG_LOG2 = 3,
   parameter int TIMEOUT  = 1024
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       clr_err,
   output logic       conv_start,
   input  logic       conv_done,
   input  logic [7:0] conv_data,
   output logic [7:0] avg_data,
   output logic       avg_valid,
   output logic [7:0] peak_max,
   output logic [7:0] peak_min,
   output logic       timeout_err,
   output logic       overrun_err
);
   // state        | meaning
   // S_IDLE       | disabled; window accumulator/count/min/max held cleared
   // S_WAIT_TICK  | waiting for the next period tick
   // S_START      | conv_start high for this cycle
   // S_CONVERT    | waiting for conv_done or timeout
   // S_OUTPUT     | avg_valid high; window cleared for the next one

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_WAIT_TICK = 3'd1;
   localparam logic [2:0] S_START     = 3'd2;
   localparam logic [2:0] S_CONVERT   = 3'd3;
   localparam logic [2:0] S_OUTPUT    = 3'd4;

   localparam int PW = (PERIOD  > 1) ? $clog2(PERIOD)  : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int AW = 8 + AVG_LOG2;
   localparam int CW = AVG_LOG2 + 1;

   localparam logic [PW-1:0] P_LAST = PW'(PERIOD - 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
   localparam logic [CW-1:0] WIN    = CW'(1) << AVG_LOG2;

   logic [2:0]    state;
   logic [PW-1:0] pcnt;
   logic [TW-1:0] tcnt;
   logic [CW-1:0] cnt;
   logic [AW-1:0] acc;
   logic [7:0]    wmin;
   logic [7:0]    wmax;
   logic          tick;
   logic [AW-1:0] acc_nxt;
   logic [7:0]    min_nxt;
   logic [7:0]    max_nxt;
   logic [2:0]    resume;

   assign tick    = enable && (pcnt == P_LAST);
   assign acc_nxt = acc + AW'(conv_data);
   assign min_nxt = (conv_data < wmin) ? conv_data : wmin;
   assign max_nxt = (conv_data > wmax) ? conv_data : wmax;
   assign resume  = enable ? S_WAIT_TICK : S_IDLE;

   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         pcnt <= '0;
      end else if (pcnt == P_LAST) begin
         pcnt <= '0;
      end else begin
         pcnt <= pcnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         tcnt        <= '0;
         cnt         <= '0;
         acc         <= '0;
         wmin        <= 8'hFF;
         wmax        <= 8'h00;
         conv_start  <= 1'b0;
         avg_valid   <= 1'b0;
         avg_data    <= 8'h00;
         peak_max    <= 8'h00;
         peak_min    <= 8'h00;
         timeout_err <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         conv_start <= 1'b0;
         avg_valid  <= 1'b0;
         // clear first so a same-cycle flag event below wins
         if (clr_err) begin
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
         end
         case (state)
            S_IDLE: begin
               acc  <= '0;
               cnt  <= '0;
               wmin <= 8'hFF;
               wmax <= 8'h00;
               if (enable) state <= S_WAIT_TICK;
            end
            S_WAIT_TICK: begin
               tcnt <= '0;
               if (!enable) begin
                  state <= S_IDLE;
               end else if (tick) begin
                  state      <= S_START;
                  conv_start <= 1'b1;
               end
            end
            S_START: begin
               tcnt  <= tcnt + 1'b1;
               state <= S_CONVERT;
            end
            S_CONVERT: begin
               tcnt <= tcnt + 1'b1;
               if (tick) overrun_err <= 1'b1;
               if (conv_done) begin
                  acc  <= acc_nxt;
                  wmin <= min_nxt;
                  wmax <= max_nxt;
                  cnt  <= cnt + 1'b1;
                  // last sample: results are registered now so they appear with OUTPUT
                  if (cnt + 1'b1 == WIN) begin
                     avg_valid <= 1'b1;
                     avg_data  <= acc_nxt[AVG_LOG2 +: 8];
                     peak_max  <= max_nxt;
                     peak_min  <= min_nxt;
                     state     <= S_OUTPUT;
                  end else begin
                     state <= resume;
                  end
               end else if (tcnt == T_LAST) begin
                  timeout_err <= 1'b1;
                  state       <= resume;
               end
            end
            S_OUTPUT: begin
               acc   <= '0;
               cnt   <= '0;
               wmin  <= 8'hFF;
               wmax  <= 8'h00;
               state <= resume;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
